kmac_pad_ctrl: RTL

KMAC_PAD_CTRL -- requirements
Module: kmac_pad_ctrl

---
 rtl/kmac_pad_ctrl_pkg.sv | 17 +
 rtl/kmac_pad_ctrl_right_enc.sv | 22 ++
 rtl/kmac_pad_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/kmac_pad_ctrl_pkg.sv
// Shared types and constants for the KMAC padding controller.
package kmac_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MSG       = 3'd1,
    ENC       = 3'd2,
    PAD       = 3'd3,
    PERM_WAIT = 3'd4,
    DONE      = 3'd5
  } kmac_state_e;

  localparam logic [7:0]  KMAC_DOMAIN_BYTE  = 8'h04;
  localparam logic [7:0]  KMAC_PAD_LAST     = 8'h80;
  localparam int unsigned KMAC_DEFAULT_RATE = 168;

endpackage

// File: rtl/kmac_pad_ctrl_right_enc.sv
// right_encode of a 16-bit length: minimal big-endian bytes followed by the byte count.
module kmac_right_enc (
  input  logic [15:0]     len_i,
  output logic [2:0][7:0] bytes_o,
  output logic [1:0]      count_o
);

  always_comb begin
    bytes_o = '0;
    if (len_i[15:8] == 8'h00) begin
      bytes_o[0] = len_i[7:0];
      bytes_o[1] = 8'h01;
      count_o    = 2'd2;
    end else begin
      bytes_o[0] = len_i[15:8];
      bytes_o[1] = len_i[7:0];
      bytes_o[2] = 8'h02;
      count_o    = 2'd3;
    end
  end

endmodule

// File: rtl/kmac_pad_ctrl.sv
// KMAC message packer: message, right_encode(L) and sponge padding into 64-bit lanes.
// Optional macro KMAC_PAD_CTRL_XOF_EN adds an xof input that forces L to be encoded as 0.
module kmac_pad_ctrl
  import kmac_pkg::*;
#(
  parameter int unsigned RATE_BYTES = KMAC_DEFAULT_RATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] out_len_bits,
`ifdef KMAC_PAD_CTRL_XOF_EN
  input  logic        xof,
`endif
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        lane_valid,
  output logic [63:0] lane_data,
  input  logic        lane_ready,
  output logic        perm_start,
  input  logic        perm_done,
  output logic        done
);

  localparam int unsigned CntW = $clog2(RATE_BYTES);
  localparam logic [CntW-1:0] RateLast = CntW'(RATE_BYTES - 1);

  kmac_state_e     state_q, state_d, resume_q, resume_d;
  logic [63:0]     lane_q, lane_d;
  logic [2:0]      fill_q, fill_d;
  logic            lane_valid_q, lane_valid_d;
  logic            blk_end_q, blk_end_d;
  logic [CntW-1:0] rate_q, rate_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      enc_idx_q, enc_idx_d;
  logic            pad_first_q, pad_first_d;
  logic            pad_done_q, pad_done_d;
  logic            perm_start_q, perm_start_d;

  logic [2:0][7:0] enc_bytes;
  logic [1:0]      enc_n;
  logic            byte_wr;
  logic [7:0]      wr_byte;
  logic            rate_last;

  kmac_right_enc u_right_enc (
    .len_i   (len_q),
    .bytes_o (enc_bytes),
    .count_o (enc_n)
  );

  assign rate_last = (rate_q == RateLast);

  // One byte per cycle enters the packer from whichever source the state selects.
  always_comb begin
    byte_wr = 1'b0;
    wr_byte = 8'h00;
    if (!lane_valid_q) begin
      case (state_q)
        MSG: begin
          byte_wr = in_valid;
          wr_byte = in_data;
        end
        ENC: begin
          byte_wr = 1'b1;
          wr_byte = enc_bytes[enc_idx_q];
        end
        PAD: begin
          byte_wr = !pad_done_q;
          wr_byte = (pad_first_q ? KMAC_DOMAIN_BYTE : 8'h00) |
                    (rate_last ? KMAC_PAD_LAST : 8'h00);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    resume_d     = resume_q;
    lane_d       = lane_q;
    fill_d       = fill_q;
    lane_valid_d = lane_valid_q;
    blk_end_d    = blk_end_q;
    rate_d       = rate_q;
    len_d        = len_q;
    enc_idx_d    = enc_idx_q;
    pad_first_d  = pad_first_q;
    pad_done_d   = pad_done_q;
    perm_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = MSG;
`ifdef KMAC_PAD_CTRL_XOF_EN
          len_d       = xof ? 16'h0000 : out_len_bits;
`else
          len_d       = out_len_bits;
`endif
          rate_d      = '0;
          fill_d      = '0;
          enc_idx_d   = '0;
          pad_first_d = 1'b1;
          pad_done_d  = 1'b0;
        end
      end
      MSG: if (byte_wr && in_last) state_d = ENC;
      ENC: begin
        if (byte_wr) begin
          if (enc_idx_q == enc_n - 2'd1) begin
            state_d   = PAD;
            enc_idx_d = '0;
          end else begin
            enc_idx_d = enc_idx_q + 2'd1;
          end
        end
      end
      PAD: begin
        if (byte_wr) begin
          pad_first_d = 1'b0;
          if (rate_last) pad_done_d = 1'b1;
        end
      end
      PERM_WAIT: if (perm_done) state_d = pad_done_q ? DONE : resume_q;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (byte_wr) begin
      lane_d[{fill_q, 3'b000} +: 8] = wr_byte;
      fill_d = fill_q + 3'd1;
      rate_d = rate_last ? '0 : rate_q + 1'b1;
      if (fill_q == 3'd7) begin
        lane_valid_d = 1'b1;
        blk_end_d    = rate_last;
      end
    end

    // Rate is a multiple of 8, so a block always ends on a lane boundary.
    if (lane_valid_q && lane_ready) begin
      lane_valid_d = 1'b0;
      lane_d       = '0;
      if (blk_end_q) begin
        blk_end_d    = 1'b0;
        perm_start_d = 1'b1;
        resume_d     = state_q;
        state_d      = PERM_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resume_q     <= IDLE;
      lane_q       <= '0;
      fill_q       <= '0;
      lane_valid_q <= 1'b0;
      blk_end_q    <= 1'b0;
      rate_q       <= '0;
      len_q        <= '0;
      enc_idx_q    <= '0;
      pad_first_q  <= 1'b0;
      pad_done_q   <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      lane_q       <= lane_d;
      fill_q       <= fill_d;
      lane_valid_q <= lane_valid_d;
      blk_end_q    <= blk_end_d;
      rate_q       <= rate_d;
      len_q        <= len_d;
      enc_idx_q    <= enc_idx_d;
      pad_first_q  <= pad_first_d;
      pad_done_q   <= pad_done_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign in_ready   = (state_q == MSG) && !lane_valid_q;
  assign lane_valid = lane_valid_q;
  assign lane_data  = lane_q;
  assign perm_start = perm_start_q;
  assign done       = (state_q == DONE);

endmodule
